vproc_vmem_bridge: RTL and testbench
====================================

Name: vproc_vmem_bridge

Overview:
Responder for the vector core's VMEM_W-bit data memory port: the memory-side end of the req/gnt/rvalid protocol the vector wrapper drives.
Accepts one wide request at a time and splits it into VMEM_W/DW sequential beats on a narrow DW-bit downstream req/gnt/rvalid port toward the data cache/interconnect.
Reassembles read data, merges errors, and returns a single wide response.
Skips write beats whose byte-enable slice is all zero.

Parameters:
VMEM_W  128  upstream data width in bits; power of two, >= DW
DW      64   downstream data width in bits; power of two
(derived) NBEAT = VMEM_W/DW; BEAT_B = DW/8; WIDE_B = VMEM_W/8

Ports:
clk_i          input   1          clock
rst_ni         input   1          asynchronous active-low reset
vmem_req_i     input   1          upstream request valid
vmem_gnt_o     output  1          upstream grant (request accepted this cycle)
vmem_addr_i    input   32         upstream byte address
vmem_we_i      input   1          1 = write
vmem_be_i      input   WIDE_B     upstream byte enables
vmem_wdata_i   input   VMEM_W     upstream write data
vmem_rvalid_o  output  1          upstream response valid (one-cycle pulse)
vmem_rdata_o   output  VMEM_W     upstream read data
vmem_err_o     output  1          upstream response error
mem_req_o      output  1          downstream beat request
mem_gnt_i      input   1          downstream grant
mem_addr_o     output  32         downstream beat byte address
mem_we_o       output  1          downstream write
mem_be_o       output  BEAT_B     downstream byte enables
mem_wdata_o    output  DW         downstream write data
mem_rvalid_i   input   1          downstream beat response, in order, at least 1 cycle after its gnt
mem_rdata_i    input   DW         downstream beat read data
mem_err_i      input   1          downstream beat error, qualified by mem_rvalid_i

Behaviour:
- Reset (rst_ni, asynchronous, active-low; clock clk_i): FSM=IDLE; counters, error flag, rdata register and all outputs 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - vmem_gnt_o = vmem_req_i, combinational; gnt is 0 in every other state.
  - On req&gnt at cycle T: latch base = addr with low log2(WIDE_B) bits cleared, plus we, be, wdata.
  - Clear rdata register and error flag.
  - Compute beat mask: all ones for reads; for writes, bit k = |be[k*BEAT_B +: BEAT_B].
  - Next state: ISSUE if mask != 0, else RESP.
- ISSUE:
  - mem_req_o=1 for the lowest pending beat k.
  - mem_addr_o = base + k*BEAT_B.
  - mem_be_o / mem_wdata_o = slice k; mem_we_o = latched we.
  - All outputs held stable until mem_gnt_i.
  - On gnt: clear beat k from the pending mask; the next pending beat is presented the following cycle with no bubble.
  - On gnt of the last pending beat: go to WAIT.
- Response tracking (ISSUE and WAIT):
  - resp_cnt counts mem_rvalid_i and ORs mem_err_i into the error flag.
  - Reads: beat resp_cnt data is written to rdata register slice resp_cnt.
  - Writes: mem_rdata_i is ignored.
- WAIT: when resp_cnt+rvalid equals the number of granted beats, go to RESP.
- RESP: vmem_rvalid_o=1 for exactly one cycle, with vmem_rdata_o = rdata register and vmem_err_o = error flag; then go to IDLE.
  - vmem_rdata_o and vmem_err_o are 0 whenever vmem_rvalid_o=0.
- Latency:
  - Zero-wait 2-beat read: response at T+4.
  - All-zero-be write: response at T+1 with no downstream traffic.
- mem_rvalid_i in IDLE or RESP (stale, e.g. after reset mid-transaction) is ignored.
- The error flag does not abort issuing; all pending beats still complete.
- Reset mid-operation abandons the transaction immediately: mem_req_o drops asynchronously and no upstream response is produced.
- Only one upstream transaction is outstanding; a new grant occurs at the earliest in the cycle after RESP.
- Address arithmetic is modulo 2^32.

Test Plan:
- Read, addr 0x1000, gnt=1, rvalid 1 cycle after gnt, beats return 0x11..11 then 0x22..22 -> mem_addr 0x1000 @T+1 and 0x1008 @T+2; vmem_rvalid_o @T+4; rdata = {0x22..22, 0x11..11}; err 0.
- Write, be=0xFF00, addr 0x2000 -> single beat at 0x2008, be 0xFF, wdata = upper 64 bits; vmem_rvalid_o one cycle after its response.
- Write, be=0x0000 -> no mem_req_o; vmem_rvalid_o @T+1; err 0.
- Read, mem_gnt_i low for 3 cycles on beat 0 -> addr/be/req held stable; beat 1 follows the gnt with no bubble; correct rdata.
- Read, mem_err_i=1 on beat 1 only -> both beats issued; vmem_err_o=1 with vmem_rvalid_o.
- Misaligned addr 0x1004 -> beats at 0x1000/0x1008. Reset asserted in WAIT, later stray mem_rvalid_i -> no vmem_rvalid_o; next request serviced normally.

Source files
------------

// File: rtl/vproc_vmem_bridge.sv
// vproc_vmem_bridge: wide-to-narrow memory bridge for the vector core.
// Takes one VMEM_W-bit request from the vector data port (req/gnt/rvalid)
// and replays it as VMEM_W/DW sequential DW-bit beats on a downstream
// req/gnt/rvalid port. Read beats are reassembled, beat errors are merged,
// and one wide response is returned. Write beats with no enabled byte
// are never issued.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   vmem_req_i/gnt_o    upstream request / grant (grant only in IDLE)
//   vmem_addr_i         upstream byte address (aligned down to WIDE_B)
//   vmem_we_i/be_i      upstream write enable / byte enables
//   vmem_wdata_i        upstream write data
//   vmem_rvalid_o       upstream single-cycle response pulse
//   vmem_rdata_o/err_o  upstream response data / error (0 when idle)
//   mem_req_o/gnt_i     downstream beat request / grant
//   mem_addr_o          downstream beat byte address
//   mem_we_o/be_o       downstream write enable / beat byte enables
//   mem_wdata_o         downstream beat write data
//   mem_rvalid_i        downstream in-order beat response
//   mem_rdata_i/err_i   downstream beat read data / error
module vproc_vmem_bridge #(
   parameter int unsigned VMEM_W = 128,
   parameter int unsigned DW     = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  vmem_req_i,
   output logic                  vmem_gnt_o,
   input  logic [31:0]           vmem_addr_i,
   input  logic                  vmem_we_i,
   input  logic [VMEM_W/8-1:0]   vmem_be_i,
   input  logic [VMEM_W-1:0]     vmem_wdata_i,
   output logic                  vmem_rvalid_o,
   output logic [VMEM_W-1:0]     vmem_rdata_o,
   output logic                  vmem_err_o,
   output logic                  mem_req_o,
   input  logic                  mem_gnt_i,
   output logic [31:0]           mem_addr_o,
   output logic                  mem_we_o,
   output logic [DW/8-1:0]       mem_be_o,
   output logic [DW-1:0]         mem_wdata_o,
   input  logic                  mem_rvalid_i,
   input  logic [DW-1:0]         mem_rdata_i,
   input  logic                  mem_err_i
);

   localparam int unsigned NBEAT  = VMEM_W / DW;
   localparam int unsigned BEAT_B = DW / 8;
   localparam int unsigned WIDE_B = VMEM_W / 8;
   localparam int unsigned CW     = $clog2(NBEAT + 1);

   localparam logic [31:0] ALIGN_MASK = ~(32'(WIDE_B) - 32'd1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

   state_e state_q, state_d;

   logic [31:0]       base_q;
   logic              we_q;
   logic [WIDE_B-1:0] be_q;
   logic [VMEM_W-1:0] wdata_q;
   logic [NBEAT-1:0]  pend_q;
   logic [CW-1:0]     gcnt_q;
   logic [CW-1:0]     rcnt_q;
   logic              err_q;
   logic [VMEM_W-1:0] rdata_q;

   logic [NBEAT-1:0]  new_mask;
   logic [NBEAT-1:0]  cur_oh;
   logic [NBEAT-1:0]  pend_clr;
   logic              accept;
   logic              issue_gnt;
   logic              resp_in;

   // Beats that must go downstream: every beat of a read, but only
   // write beats carrying at least one enabled byte.
   always_comb begin
      new_mask = '0;
      for (int k = 0; k < NBEAT; k++) begin
         new_mask[k] = vmem_we_i ? |vmem_be_i[k*BEAT_B +: BEAT_B] : 1'b1;
      end
   end

   // One-hot of the lowest pending beat.
   always_comb begin
      cur_oh = '0;
      for (int k = NBEAT - 1; k >= 0; k--) begin
         if (pend_q[k]) begin
            cur_oh    = '0;
            cur_oh[k] = 1'b1;
         end
      end
   end

   assign pend_clr  = pend_q & ~cur_oh;
   assign accept    = (state_q == IDLE) && vmem_req_i;
   assign issue_gnt = (state_q == ISSUE) && mem_gnt_i;
   assign resp_in   = ((state_q == ISSUE) || (state_q == WAIT)) &&
                      mem_rvalid_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (vmem_req_i) begin
               state_d = (|new_mask) ? ISSUE : RESP;
            end
         end
         ISSUE: begin
            if (mem_gnt_i && (pend_clr == '0)) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            // The last response can only arrive here, since every
            // response trails its grant by at least one cycle.
            if ((rcnt_q + CW'(mem_rvalid_i)) == gcnt_q) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      vmem_gnt_o    = 1'b0;
      vmem_rvalid_o = 1'b0;
      vmem_rdata_o  = '0;
      vmem_err_o    = 1'b0;
      mem_req_o     = 1'b0;
      mem_addr_o    = '0;
      mem_we_o      = 1'b0;
      mem_be_o      = '0;
      mem_wdata_o   = '0;
      unique case (state_q)
         IDLE: begin
            vmem_gnt_o = vmem_req_i;
         end
         ISSUE: begin
            mem_req_o = 1'b1;
            mem_we_o  = we_q;
            for (int k = 0; k < NBEAT; k++) begin
               if (cur_oh[k]) begin
                  mem_addr_o  = base_q + 32'(k * BEAT_B);
                  mem_be_o    = be_q[k*BEAT_B +: BEAT_B];
                  mem_wdata_o = wdata_q[k*DW +: DW];
               end
            end
         end
         RESP: begin
            vmem_rvalid_o = 1'b1;
            vmem_rdata_o  = rdata_q;
            vmem_err_o    = err_q;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         base_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         pend_q  <= '0;
         gcnt_q  <= '0;
         rcnt_q  <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         if (accept) begin
            base_q  <= vmem_addr_i & ALIGN_MASK;
            we_q    <= vmem_we_i;
            be_q    <= vmem_be_i;
            wdata_q <= vmem_wdata_i;
            pend_q  <= new_mask;
            gcnt_q  <= '0;
            rcnt_q  <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
         end
         if (issue_gnt) begin
            pend_q <= pend_clr;
            gcnt_q <= gcnt_q + CW'(1);
         end
         // Responses come back in grant order, so the response count
         // doubles as the slice index of the incoming read beat.
         if (resp_in) begin
            rcnt_q <= rcnt_q + CW'(1);
            err_q  <= err_q | mem_err_i;
            if (!we_q) begin
               for (int k = 0; k < NBEAT; k++) begin
                  if (rcnt_q == CW'(k)) begin
                     rdata_q[k*DW +: DW] <= mem_rdata_i;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vproc_vmem_bridge.sv
// tb_vproc_vmem_bridge: self-checking bench for vproc_vmem_bridge.
// Table vectors, corner-case sequences and random traffic vs. a memory model.
module tb_vproc_vmem_bridge;

   logic           clk = 1'b0;
   logic           rst_ni = 1'b0;
   logic           vmem_req_i = 1'b0;
   logic           vmem_gnt_o;
   logic [31:0]    vmem_addr_i = '0;
   logic           vmem_we_i = 1'b0;
   logic [15:0]    vmem_be_i = '0;
   logic [127:0]   vmem_wdata_i = '0;
   logic           vmem_rvalid_o;
   logic [127:0]   vmem_rdata_o;
   logic           vmem_err_o;
   logic           mem_req_o;
   logic           mem_gnt_i = 1'b0;
   logic [31:0]    mem_addr_o;
   logic           mem_we_o;
   logic [7:0]     mem_be_o;
   logic [63:0]    mem_wdata_o;
   logic           mem_rvalid_i = 1'b0;
   logic [63:0]    mem_rdata_i = '0;
   logic           mem_err_i = 1'b0;

   always #5 clk = ~clk;

   vproc_vmem_bridge #(.VMEM_W(128), .DW(64)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .vmem_req_i    (vmem_req_i),
      .vmem_gnt_o    (vmem_gnt_o),
      .vmem_addr_i   (vmem_addr_i),
      .vmem_we_i     (vmem_we_i),
      .vmem_be_i     (vmem_be_i),
      .vmem_wdata_i  (vmem_wdata_i),
      .vmem_rvalid_o (vmem_rvalid_o),
      .vmem_rdata_o  (vmem_rdata_o),
      .vmem_err_o    (vmem_err_o),
      .mem_req_o     (mem_req_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_addr_o    (mem_addr_o),
      .mem_we_o      (mem_we_o),
      .mem_be_o      (mem_be_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .mem_err_i     (mem_err_i)
   );

   int total = 0;
   int bad = 0;
   int unsigned cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // Downstream memory model: 64-bit words keyed by beat address.
   logic [63:0] mem [logic [31:0]];
   bit          err_set [logic [31:0]];

   function automatic logic [63:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a, ~a};
   endfunction

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [7:0]  be;
      logic [63:0] wdata;
      int unsigned c;
   } beat_t;

   typedef struct {
      int unsigned due;
      logic [63:0] d;
      logic        e;
   } rsp_t;

   beat_t obs[$];
   rsp_t  rq[$];
   int stall_pct = 0;
   int resp_min = 0;
   int resp_extra = 0;
   int force_stall = 0;

   // Downstream responder: random grants, in-order delayed responses.
   initial begin : responder
      logic [104:0] hv, held;
      bit hold_v;
      logic g;
      hold_v = 0;
      forever begin
         @(negedge clk);
         if (rq.size() > 0 && rq[0].due <= cyc) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rq[0].d;
            mem_err_i    = rq[0].e;
            void'(rq.pop_front());
         end else begin
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = {$urandom, $urandom};
            mem_err_i    = 1'($urandom_range(1));
         end
         hv = {mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o};
         if (mem_req_o && rst_ni) begin
            if (hold_v) check("req_hold", 128'(hv), 128'(held));
            if (force_stall > 0) begin
               g = 1'b0;
               force_stall--;
            end else begin
               g = ($urandom_range(99) >= stall_pct);
            end
            if (g) begin
               beat_t b;
               rsp_t r;
               logic [63:0] w;
               hold_v = 0;
               b.addr = mem_addr_o;
               b.we = mem_we_o;
               b.be = mem_be_o;
               b.wdata = mem_wdata_o;
               b.c = cyc;
               obs.push_back(b);
               r.d = mem_rd(mem_addr_o);
               r.e = err_set.exists(mem_addr_o);
               r.due = cyc + 1 + resp_min + $urandom_range(resp_extra);
               if (mem_we_o) begin
                  w = mem_rd(mem_addr_o);
                  for (int i = 0; i < 8; i++)
                     if (mem_be_o[i]) w[i*8 +: 8] = mem_wdata_o[i*8 +: 8];
                  mem[mem_addr_o] = w;
                  r.d = {$urandom, $urandom};
               end
               rq.push_back(r);
            end else begin
               held = hv;
               hold_v = 1;
            end
         end else begin
            hold_v = 0;
            g = 1'($urandom_range(1));
         end
         mem_gnt_i = g;
      end
   end

   // One upstream transaction, checked against the model.
   task automatic txn(input logic [31:0] a, input logic we,
                      input logic [15:0] be, input logic [127:0] wd,
                      output int lat, output int g0, output int g1,
                      output logic [127:0] rd, output logic er);
      logic [31:0] base;
      logic [127:0] exp_rd;
      logic exp_err;
      beat_t exp_q[$];
      int n;
      int unsigned t0;
      base = a & ~32'hF;
      exp_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
         beat_t b;
         b.addr = base + 32'(8 * k);
         b.we = we;
         b.be = be[k*8 +: 8];
         b.wdata = wd[k*64 +: 64];
         b.c = 0;
         if (!we || (b.be != 8'h00)) begin
            exp_q.push_back(b);
            if (err_set.exists(b.addr)) exp_err = 1'b1;
         end
      end
      exp_rd = we ? 128'h0 : {mem_rd(base + 32'd8), mem_rd(base)};
      obs.delete();
      @(negedge clk);
      vmem_req_i = 1'b1;
      vmem_addr_i = a;
      vmem_we_i = we;
      vmem_be_i = be;
      vmem_wdata_i = wd;
      n = 0;
      #1;
      while (!vmem_gnt_o && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("gnt", 128'(vmem_gnt_o), 128'(1));
      t0 = cyc;
      @(negedge clk);
      vmem_req_i = 1'b0;
      vmem_addr_i = $urandom;
      n = 0;
      while (!vmem_rvalid_o && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("rvalid", 128'(vmem_rvalid_o), 128'(1));
      lat = int'(cyc - t0);
      rd = vmem_rdata_o;
      er = vmem_err_o;
      check("rdata", vmem_rdata_o, exp_rd);
      check("err", 128'(vmem_err_o), 128'(exp_err));
      @(negedge clk);
      check("resp_idle", {vmem_rvalid_o, vmem_err_o, vmem_rdata_o}, '0);
      check("nbeats", 128'(obs.size()), 128'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
         check("beat",
               {obs[i].addr, obs[i].be, obs[i].we, obs[i].wdata},
               {exp_q[i].addr, exp_q[i].be, exp_q[i].we, exp_q[i].wdata});
      g0 = (obs.size() > 0) ? int'(obs[0].c - t0) : -1;
      g1 = (obs.size() > 1) ? int'(obs[1].c - obs[0].c) : -1;
   endtask

   typedef struct {
      logic [31:0]  addr;
      logic         we;
      logic [15:0]  be;
      logic [127:0] wd;
      int           lat;
      int           nb;
      int           g0;
      logic [31:0]  a0;
      bit           chk_rd;
      logic [127:0] rd;
   } vec_t;

   initial begin : watchdog
      #3000000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t tbl[7];
      int lat, g0, g1, seen;
      logic [127:0] rd;
      logic er;
      logic [15:0] be;

      tbl[0] = '{32'h1000, 1'b0, 16'hFFFF, '0, 4, 2, 1, 32'h1000,
                 1'b1, {{8{8'h22}}, {8{8'h11}}}};
      tbl[1] = '{32'h2000, 1'b1, 16'hFF00,
                 {64'hA5A5_0101_C3C3_7E7E, 64'h5A5A_0202_3C3C_E7E7},
                 3, 1, 1, 32'h2008, 1'b0, '0};
      tbl[2] = '{32'h2100, 1'b1, 16'h0000, {4{32'hDEADBEEF}},
                 1, 0, -1, 32'h0, 1'b1, '0};
      tbl[3] = '{32'h1004, 1'b0, 16'hFFFF, '0, 4, 2, 1, 32'h1000,
                 1'b1, {{8{8'h22}}, {8{8'h11}}}};
      tbl[4] = '{32'h3000, 1'b1, 16'hFFFF, {4{32'h0BADF00D}},
                 4, 2, 1, 32'h3000, 1'b0, '0};
      tbl[5] = '{32'h300F, 1'b1, 16'h0100, {4{32'h12345678}},
                 3, 1, 1, 32'h3008, 1'b0, '0};
      tbl[6] = '{32'hFFFF_FFF8, 1'b0, 16'hFFFF, '0, 4, 2, 1,
                 32'hFFFF_FFF0, 1'b0, '0};

      mem[32'h1000] = {8{8'h11}};
      mem[32'h1008] = {8{8'h22}};

      #12;
      check("rst_gnt", 128'(vmem_gnt_o), 128'(0));
      check("rst_mem", {mem_req_o, mem_we_o, mem_be_o, mem_addr_o,
                        mem_wdata_o}, '0);
      check("rst_resp", {vmem_rvalid_o, vmem_err_o, vmem_rdata_o}, '0);
      @(negedge clk);
      rst_ni = 1'b1;
      @(negedge clk);
      check("idle_mem_req", 128'(mem_req_o), 128'(0));

      // Zero-wait table vectors.
      for (int i = 0; i < 7; i++) begin
         txn(tbl[i].addr, tbl[i].we, tbl[i].be, tbl[i].wd,
             lat, g0, g1, rd, er);
         check($sformatf("tbl%0d_lat", i), 128'(lat), 128'(tbl[i].lat));
         check($sformatf("tbl%0d_g0", i), 128'(g0), 128'(tbl[i].g0));
         if (tbl[i].nb > 0)
            check($sformatf("tbl%0d_a0", i), 128'(obs[0].addr),
                  128'(tbl[i].a0));
         if (tbl[i].chk_rd)
            check($sformatf("tbl%0d_rd", i), rd, tbl[i].rd);
      end

      // Beat 0 stalled three cycles; beat 1 follows with no bubble.
      force_stall = 3;
      txn(32'h1000, 1'b0, 16'hFFFF, '0, lat, g0, g1, rd, er);
      check("stall_g0", 128'(g0), 128'(4));
      check("stall_g1", 128'(g1), 128'(1));
      check("stall_lat", 128'(lat), 128'(7));
      check("stall_rd", rd, {{8{8'h22}}, {8{8'h11}}});

      // Error on beat 1 only.
      err_set[32'h4008] = 1'b1;
      txn(32'h4000, 1'b0, 16'hFFFF, '0, lat, g0, g1, rd, er);
      check("err_flag", 128'(er), 128'(1));
      check("err_beats", 128'(obs.size()), 128'(2));
      err_set.delete();

      // Reset during ISSUE drops mem_req_o asynchronously.
      force_stall = 1000;
      @(negedge clk);
      vmem_req_i = 1'b1;
      vmem_addr_i = 32'h5000;
      vmem_we_i = 1'b0;
      vmem_be_i = 16'hFFFF;
      #1;
      check("rsti_gnt", 128'(vmem_gnt_o), 128'(1));
      @(negedge clk);
      vmem_req_i = 1'b0;
      #1;
      check("rsti_req", 128'(mem_req_o), 128'(1));
      #2;
      rst_ni = 1'b0;
      #1;
      check("rsti_drop", {mem_req_o, mem_addr_o}, '0);
      @(negedge clk);
      force_stall = 0;
      @(negedge clk);
      rst_ni = 1'b1;

      // Reset during WAIT; the stray responses must be ignored.
      resp_min = 8;
      obs.delete();
      @(negedge clk);
      vmem_req_i = 1'b1;
      vmem_addr_i = 32'h6000;
      vmem_we_i = 1'b0;
      vmem_be_i = 16'hFFFF;
      #1;
      check("rstw_gnt", 128'(vmem_gnt_o), 128'(1));
      @(negedge clk);
      vmem_req_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rstw_issued", 128'(obs.size()), 128'(2));
      check("rstw_wait", {mem_req_o, vmem_rvalid_o}, '0);
      #2;
      rst_ni = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      resp_min = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (vmem_rvalid_o) seen++;
      end
      check("rstw_stray", 128'(seen), 128'(0));
      check("rstw_drained", 128'(rq.size()), 128'(0));
      txn(32'h6000, 1'b0, 16'hFFFF, '0, lat, g0, g1, rd, er);
      check("rstw_next_lat", 128'(lat), 128'(4));

      // Random traffic.
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic we;
         a = $urandom;
         b = a & ~32'hF;
         we = 1'($urandom_range(1));
         case ($urandom_range(4))
            0: be = 16'h0000;
            1: be = 16'h00FF;
            2: be = 16'hFF00;
            3: be = 16'hFFFF;
            default: be = 16'($urandom);
         endcase
         err_set.delete();
         if ($urandom_range(7) == 0) err_set[b] = 1'b1;
         if ($urandom_range(7) == 0) err_set[b + 32'd8] = 1'b1;
         stall_pct = $urandom_range(60);
         resp_extra = $urandom_range(3);
         repeat ($urandom_range(2)) @(negedge clk);
         txn(a, we, be, {$urandom, $urandom, $urandom, $urandom},
             lat, g0, g1, rd, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
